adsr_envelope: RTL

//  ADSR envelope generator for one voice. Sits directly upstream of the amplitude modulator.

---
 rtl/adsr_envelope.sv | 109 ++++++++++
 1 files changed

// File: rtl/adsr_envelope.sv
// ADSR envelope generator for one voice: gate-driven attack/decay/sustain/release
// accumulator advanced by a per-sample tick, amplitude taken from the accumulator MSBs.
module adsr_envelope #(
  parameter int ACC_BITS       = 16,
  parameter int AMPLITUDE_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      gate,
  input  logic [3:0]                attack,
  input  logic [3:0]                decay,
  input  logic [3:0]                sustain,
  // "release" is a reserved word in SystemVerilog, hence the suffix
  input  logic [3:0]                release_rate,
  output logic [AMPLITUDE_BITS-1:0] amplitude,
  output logic                      active
);

  localparam int W = ACC_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

  state_t              state;
  logic [ACC_BITS-1:0] acc;
  logic                gate_q;

  logic [3:0]   rate;
  logic [W-1:0] step;
  logic [W-1:0] acc_w;
  logic [W-1:0] target_w;
  logic [W-1:0] max_w;
  logic [W-1:0] sum_w;
  logic         rise;
  logic         fall;

  always_comb begin
    rate = release_rate;
    case (state)
      S_ATTACK: rate = attack;
      S_DECAY:  rate = decay;
      default:  rate = release_rate;
    endcase
  end

  // all arithmetic one bit wider than acc so sums and compares never wrap
  assign step     = W'(1) << rate;
  assign acc_w    = {1'b0, acc};
  assign target_w = W'({sustain, sustain}) << (ACC_BITS - 8);
  assign max_w    = {1'b0, {ACC_BITS{1'b1}}};
  assign sum_w    = acc_w + step;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & ((state == S_ATTACK) | (state == S_DECAY) | (state == S_SUSTAIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      gate_q <= 1'b0;
    end else begin
      gate_q <= gate;
      if (rise) begin
        state <= S_ATTACK;
      end else if (fall) begin
        state <= S_RELEASE;
      end else begin
        case (state)
          S_ATTACK: if (tick) begin
            if (sum_w >= max_w) begin
              acc   <= {ACC_BITS{1'b1}};
              state <= S_DECAY;
            end else begin
              acc <= sum_w[ACC_BITS-1:0];
            end
          end
          S_DECAY: if (tick) begin
            if (acc_w <= target_w + step) begin
              acc   <= target_w[ACC_BITS-1:0];
              state <= S_SUSTAIN;
            end else begin
              acc <= acc - step[ACC_BITS-1:0];
            end
          end
          S_SUSTAIN: acc <= target_w[ACC_BITS-1:0];
          S_RELEASE: if (tick) begin
            if (acc_w <= step) begin
              acc   <= '0;
              state <= S_IDLE;
            end else begin
              acc <= acc - step[ACC_BITS-1:0];
            end
          end
          default: acc <= '0;
        endcase
      end
    end
  end

  assign amplitude = acc[ACC_BITS-1 -: AMPLITUDE_BITS];
  assign active    = (state != S_IDLE);

endmodule
